// File: rtl/dm_slave_arbiter_pkg.sv
// Shared types for the debug-module slave-port arbiter.
// Host ids, owner-pipe entry layout and latency limit.
package dm_arb_pkg;

    typedef enum logic {
        HOST_CORE = 1'b0,
        HOST_DBG  = 1'b1
    } host_e;

    typedef struct packed {
        logic  valid;
        host_e owner;
    } owner_ent_t;

    localparam int OWNER_ENT_W       = $bits(owner_ent_t);
    localparam int MAX_SLAVE_LATENCY = 4;

    function automatic host_e other_host(host_e h);
        return (h == HOST_CORE) ? HOST_DBG : HOST_CORE;
    endfunction

endpackage

// File: rtl/dm_slave_arbiter_if.sv
// Bus bundle between the two hosts, the arbiter and the dm slave port.
// Modports: slave = arbiter side, master = hosts + slave memory side.
interface dm_slave_arbiter_if #(
    parameter int XLEN = 32
);
    // host 0: core device bus
    logic              h0_req_i;
    logic [XLEN-1:0]   h0_addr_i;
    logic              h0_we_i;
    logic [XLEN/8-1:0] h0_be_i;
    logic [XLEN-1:0]   h0_wdata_i;
    logic              h0_gnt_o;
    logic              h0_rvalid_o;
    logic [XLEN-1:0]   h0_rdata_o;
    // host 1: debug instruction fetch
    logic              h1_req_i;
    logic [XLEN-1:0]   h1_addr_i;
    logic              h1_gnt_o;
    logic              h1_rvalid_o;
    logic [XLEN-1:0]   h1_rdata_o;
    // slave memory port
    logic              s_req_o;
    logic              s_we_o;
    logic [XLEN-1:0]   s_addr_o;
    logic [XLEN/8-1:0] s_be_o;
    logic [XLEN-1:0]   s_wdata_o;
    logic [XLEN-1:0]   s_rdata_i;

    modport slave (
        input  h0_req_i, h0_addr_i, h0_we_i, h0_be_i, h0_wdata_i,
        output h0_gnt_o, h0_rvalid_o, h0_rdata_o,
        input  h1_req_i, h1_addr_i,
        output h1_gnt_o, h1_rvalid_o, h1_rdata_o,
        output s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o,
        input  s_rdata_i
    );

    modport master (
        output h0_req_i, h0_addr_i, h0_we_i, h0_be_i, h0_wdata_i,
        input  h0_gnt_o, h0_rvalid_o, h0_rdata_o,
        output h1_req_i, h1_addr_i,
        input  h1_gnt_o, h1_rvalid_o, h1_rdata_o,
        input  s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o,
        output s_rdata_i
    );

endinterface

// File: rtl/dm_slave_arbiter_resp_pipe.sv
// Owner shift register: one {valid, owner} entry per cycle, DEPTH deep.
// Ports: clk, rst_ni (async clear), i_push/i_owner in, o_head_* out.
module dm_arb_resp_pipe
    import dm_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst_ni,
    input  logic  i_push,
    input  host_e i_owner,
    output logic  o_head_valid,
    output host_e o_head_owner
);

    owner_ent_t r_pipe [DEPTH];

    // Reset drops every in-flight entry, so no late rvalid can escape.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= '{valid: i_push, owner: i_owner};
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_head_valid = r_pipe[DEPTH-1].valid;
    assign o_head_owner = r_pipe[DEPTH-1].owner;

endmodule

// File: rtl/dm_slave_arbiter.sv
// Two-host arbiter for the debug module slave port (core bus + dbg fetch).
// Ports: clk, rst_ni, bus (dm_slave_arbiter_if.slave).
// Build option DM_ARB_RR_EN: round-robin on contention, else host 0 first.
// SLAVE_LATENCY (1..MAX_SLAVE_LATENCY) is the slave's fixed read latency.
module dm_slave_arbiter
    import dm_arb_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int SLAVE_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_ni,
    dm_slave_arbiter_if.slave   bus
);

    localparam int BE_W = XLEN / 8;

    logic  w_any_req;
    host_e w_sel;
    host_e w_contend_winner;
    logic  w_head_valid;
    host_e w_head_owner;

`ifdef DM_ARB_RR_EN
    // Points at the host favoured on the next contention.
    host_e r_rr_ptr;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= HOST_CORE;
        end else if (w_any_req) begin
            r_rr_ptr <= other_host(w_sel);
        end
    end

    assign w_contend_winner = r_rr_ptr;
`else
    assign w_contend_winner = HOST_CORE;
`endif

    // Gated by rst_ni so nothing is granted while reset is held.
    always_comb begin
        w_any_req = rst_ni & (bus.h0_req_i | bus.h1_req_i);
        w_sel     = HOST_CORE;
        if (bus.h0_req_i && bus.h1_req_i) begin
            w_sel = w_contend_winner;
        end else if (bus.h1_req_i) begin
            w_sel = HOST_DBG;
        end
    end

    always_comb begin
        bus.h0_gnt_o  = 1'b0;
        bus.h1_gnt_o  = 1'b0;
        bus.s_req_o   = 1'b0;
        bus.s_we_o    = 1'b0;
        bus.s_addr_o  = '0;
        bus.s_be_o    = '0;
        bus.s_wdata_o = '0;
        if (w_any_req) begin
            bus.s_req_o = 1'b1;
            unique case (w_sel)
                HOST_CORE: begin
                    bus.h0_gnt_o  = 1'b1;
                    bus.s_we_o    = bus.h0_we_i;
                    bus.s_addr_o  = bus.h0_addr_i;
                    bus.s_be_o    = bus.h0_be_i;
                    bus.s_wdata_o = bus.h0_wdata_i;
                end
                HOST_DBG: begin
                    // Fetch path is read-only, full word.
                    bus.h1_gnt_o  = 1'b1;
                    bus.s_addr_o  = bus.h1_addr_i;
                    bus.s_be_o    = {BE_W{1'b1}};
                end
                default: ;
            endcase
        end
    end

    dm_arb_resp_pipe #(
        .DEPTH (SLAVE_LATENCY)
    ) u_resp_pipe (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .i_push       (w_any_req),
        .i_owner      (w_sel),
        .o_head_valid (w_head_valid),
        .o_head_owner (w_head_owner)
    );

    assign bus.h0_rvalid_o = w_head_valid & (w_head_owner == HOST_CORE);
    assign bus.h1_rvalid_o = w_head_valid & (w_head_owner == HOST_DBG);
    assign bus.h0_rdata_o  = bus.h0_rvalid_o ? bus.s_rdata_i : '0;
    assign bus.h1_rdata_o  = bus.h1_rvalid_o ? bus.s_rdata_i : '0;

endmodule

// File: tb/tb_dm_slave_arbiter.sv
// Bench for dm_slave_arbiter: latency-1 and latency-3 instances, shared
// host stimulus, per-instance response scoreboards.
module tb_dm_slave_arbiter;
    import dm_arb_pkg::*;

    typedef struct {
        int          owner;
        bit          is_wr;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    int   cyc    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   exp_w[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_slave_arbiter_if #(.XLEN(32)) ifa ();
    dm_slave_arbiter_if #(.XLEN(32)) ifb ();

    dm_slave_arbiter #(.XLEN(32), .SLAVE_LATENCY(1)) u_dut_l1 (
        .clk    (clk),
        .rst_ni (rst_ni),
        .bus    (ifa)
    );

    dm_slave_arbiter #(.XLEN(32), .SLAVE_LATENCY(3)) u_dut_l3 (
        .clk    (clk),
        .rst_ni (rst_ni),
        .bus    (ifb)
    );

    function automatic logic [31:0] slave_data(logic [31:0] a);
        case (a)
            32'hCD00_0100: return 32'hDEAD_BEEF;
            32'hCD00_0800: return 32'h0000_0013;
            32'hCD00_0104: return 32'hCAFE_F00D;
            default:       return 32'h5A5A_5A5A;
        endcase
    endfunction

    // Fixed-latency slave memories
    logic        va = 1'b0;
    logic [31:0] aa = '0;
    logic [2:0]  vb = '0;
    logic [31:0] ab [3];

    always @(posedge clk) begin
        va    <= ifa.s_req_o;
        aa    <= ifa.s_addr_o;
        vb    <= {vb[1:0], ifb.s_req_o};
        ab[0] <= ifb.s_addr_o;
        ab[1] <= ab[0];
        ab[2] <= ab[1];
    end

    assign ifa.s_rdata_i = va ? slave_data(aa) : '0;
    assign ifb.s_rdata_i = vb[2] ? slave_data(ab[2]) : '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic drive(bit r0, logic [31:0] a0, bit w0, logic [3:0] b0,
                         logic [31:0] d0, bit r1, logic [31:0] a1);
        ifa.h0_req_i = r0; ifa.h0_addr_i = a0; ifa.h0_we_i = w0;
        ifa.h0_be_i = b0; ifa.h0_wdata_i = d0;
        ifa.h1_req_i = r1; ifa.h1_addr_i = a1;
        ifb.h0_req_i = r0; ifb.h0_addr_i = a0; ifb.h0_we_i = w0;
        ifb.h0_be_i = b0; ifb.h0_wdata_i = d0;
        ifb.h1_req_i = r1; ifb.h1_addr_i = a1;
    endtask

    task automatic check_port(string nm, int win, bit w0, logic [31:0] a0,
                              logic [3:0] b0, logic [31:0] d0,
                              logic [31:0] a1, logic g0, logic g1,
                              logic sr, logic sw, logic [31:0] sa,
                              logic [3:0] sb, logic [31:0] sd);
        logic        eg0 = (win == 0);
        logic        eg1 = (win == 1);
        logic        esw = 1'b0;
        logic [31:0] esa = '0;
        logic [3:0]  esb = '0;
        logic [31:0] esd = '0;
        if (win == 0) begin
            esw = w0; esa = a0; esb = b0; esd = d0;
        end else if (win == 1) begin
            esa = a1; esb = 4'hF;
        end
        chk({nm, " h0_gnt"}, 32'(g0), 32'(eg0));
        chk({nm, " h1_gnt"}, 32'(g1), 32'(eg1));
        chk({nm, " s_req"}, 32'(sr), 32'(win >= 0));
        chk({nm, " s_we"}, 32'(sw), 32'(esw));
        chk({nm, " s_addr"}, sa, esa);
        chk({nm, " s_be"}, 32'(sb), 32'(esb));
        chk({nm, " s_wdata"}, sd, esd);
    endtask

    task automatic check_both(string nm, int win, bit w0, logic [31:0] a0,
                              logic [3:0] b0, logic [31:0] d0,
                              logic [31:0] a1);
        check_port({nm, "/L1"}, win, w0, a0, b0, d0, a1,
                   ifa.h0_gnt_o, ifa.h1_gnt_o, ifa.s_req_o, ifa.s_we_o,
                   ifa.s_addr_o, ifa.s_be_o, ifa.s_wdata_o);
        check_port({nm, "/L3"}, win, w0, a0, b0, d0, a1,
                   ifb.h0_gnt_o, ifb.h1_gnt_o, ifb.s_req_o, ifb.s_we_o,
                   ifb.s_addr_o, ifb.s_be_o, ifb.s_wdata_o);
    endtask

    // One cycle of stimulus; win is the hand-computed winner (-1 = none).
    task automatic issue(string nm, bit r0, logic [31:0] a0, bit w0,
                         logic [3:0] b0, logic [31:0] d0, bit r1,
                         logic [31:0] a1, int win);
        exp_t e;
        @(posedge clk); #1;
        drive(r0, a0, w0, b0, d0, r1, a1);
        #3;
        check_both(nm, win, w0, a0, b0, d0, a1);
        if (win >= 0) begin
            e.owner = win;
            e.is_wr = (win == 0) && w0;
            e.data  = slave_data(win == 0 ? a0 : a1);
            e.due   = cyc + 1;
            qa.push_back(e);
            e.due   = cyc + 3;
            qb.push_back(e);
        end
    endtask

    task automatic idle(int n);
        repeat (n) issue("idle", 0, '0, 0, '0, '0, 0, '0, -1);
    endtask

    // Holds both requests high during reset: nothing may be granted.
    task automatic do_reset(int n);
        @(posedge clk); #1;
        rst_ni = 1'b0;
        drive(1, 32'hCD00_0100, 1, 4'hF, 32'hFFFF_FFFF, 1, 32'hCD00_0800);
        qa.delete();
        qb.delete();
        repeat (n) begin
            #3;
            check_both("reset", -1, 1, 32'hCD00_0100, 4'hF,
                       32'hFFFF_FFFF, 32'hCD00_0800);
            @(posedge clk); #1;
        end
        rst_ni = 1'b1;
        drive(0, '0, 0, '0, '0, 0, '0);
    endtask

    task automatic resp_chk(string nm, exp_t e, logic v0, logic v1,
                            logic [31:0] d0, logic [31:0] d1);
        chk({nm, " rvalid timing"}, 32'(cyc), 32'(e.due));
        chk({nm, " h0_rvalid"}, 32'(v0), 32'(e.owner == 0));
        chk({nm, " h1_rvalid"}, 32'(v1), 32'(e.owner == 1));
        if (e.owner == 0) begin
            if (!e.is_wr) chk({nm, " h0_rdata"}, d0, e.data);
            chk({nm, " h1_rdata idle"}, d1, '0);
        end else begin
            chk({nm, " h1_rdata"}, d1, e.data);
            chk({nm, " h0_rdata idle"}, d0, '0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_ni) begin
            chk("L1 rst rvalid", 32'({ifa.h0_rvalid_o, ifa.h1_rvalid_o}), '0);
            chk("L1 rst rdata", ifa.h0_rdata_o | ifa.h1_rdata_o, '0);
        end else if (ifa.h0_rvalid_o || ifa.h1_rvalid_o) begin
            if (qa.size() == 0) begin
                chk("L1 unexpected rvalid", 32'd1, 32'd0);
            end else begin
                ea = qa.pop_front();
                resp_chk("L1", ea, ifa.h0_rvalid_o, ifa.h1_rvalid_o,
                         ifa.h0_rdata_o, ifa.h1_rdata_o);
            end
        end else if (qa.size() != 0 && qa[0].due <= cyc) begin
            chk("L1 rvalid missing", 32'd0, 32'd1);
            void'(qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst_ni) begin
            chk("L3 rst rvalid", 32'({ifb.h0_rvalid_o, ifb.h1_rvalid_o}), '0);
            chk("L3 rst rdata", ifb.h0_rdata_o | ifb.h1_rdata_o, '0);
        end else if (ifb.h0_rvalid_o || ifb.h1_rvalid_o) begin
            if (qb.size() == 0) begin
                chk("L3 unexpected rvalid", 32'd1, 32'd0);
            end else begin
                eb = qb.pop_front();
                resp_chk("L3", eb, ifb.h0_rvalid_o, ifb.h1_rvalid_o,
                         ifb.h0_rdata_o, ifb.h1_rdata_o);
            end
        end else if (qb.size() != 0 && qb[0].due <= cyc) begin
            chk("L3 rvalid missing", 32'd0, 32'd1);
            void'(qb.pop_front());
        end
    end

    initial begin
`ifdef DM_ARB_RR_EN
        exp_w = '{0, 1, 0, 1, 1};
`else
        exp_w = '{0, 0, 0, 0, 1};
`endif
        drive(0, '0, 0, '0, '0, 0, '0);
        do_reset(2);
        idle(1);

        issue("h0 read", 1, 32'hCD00_0100, 0, 4'hF, '0, 0, '0, 0);
        idle(4);
        issue("h1 fetch", 0, '0, 0, '0, '0, 1, 32'hCD00_0800, 1);
        idle(4);
        issue("h0 write", 1, 32'hCD00_0104, 1, 4'b0011, 32'h0000_1234,
              0, '0, 0);
        idle(4);

        issue("b2b h0", 1, 32'hCD00_0100, 0, 4'hF, '0, 0, '0, 0);
        issue("b2b h1", 0, '0, 0, '0, '0, 1, 32'hCD00_0800, 1);
        issue("b2b h0b", 1, 32'hCD00_0104, 0, 4'hF, '0, 0, '0, 0);
        idle(4);

        issue("pre-rst h0", 1, 32'hCD00_0100, 0, 4'hF, '0, 0, '0, 0);
        issue("pre-rst h1", 0, '0, 0, '0, '0, 1, 32'hCD00_0800, 1);
        do_reset(2);

        for (int i = 0; i < 4; i++) begin
            issue($sformatf("contend%0d", i), 1, 32'hCD00_0100, 0, 4'hF,
                  '0, 1, 32'hCD00_0800, exp_w[i]);
        end
        issue("contend4", 0, '0, 0, '0, '0, 1, 32'hCD00_0800, exp_w[4]);
        idle(5);

        chk("L1 queue drained", 32'(qa.size()), 32'd0);
        chk("L3 queue drained", 32'(qb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
